load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 5, meaning word-address width of data memory (32 words).
REQ-002 SHALL have parameter OFFSET_W, default 16, meaning width of the signed immediate offset.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  instruction presented; in_ready output 1 block can accept.
REQ-006 in_opcode  input  6  MIPS opcode (0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2B sw).
REQ-007 in_base input 32 rs value; in_offset input OFFSET_W immediate; in_wdata input 32 rt value; in_rt input 5 destination register.
REQ-008 mem_req output 1; mem_we output 1; mem_addr output MEM_AW word index; mem_be output 4 byte enables; mem_wdata output 32.
REQ-009 mem_ack  input  1  memory completed the request; mem_rdata input 32 read word.
REQ-010 out_valid output 1; out_wb output 1 (write register file); out_rt output 5; out_data output 32; out_err output 1.

Function
REQ-011 SHALL implement FSM IDLE -> REQ -> WAIT -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-012 SHALL, on in_valid&&in_ready, latch all inputs and eff = in_base + sign-extended in_offset (32-bit, wrap-around modulo 2^32), enter REQ.
REQ-013 SHALL, in REQ, drive mem_req=1, mem_addr=eff[MEM_AW+1:2], then go to WAIT next cycle; mem_req held 1 through WAIT until mem_ack.
REQ-014 SHALL drive mem_we=1 for 0x28/0x29/0x2B, else 0; mem_be = 0001<<eff[1:0] (byte), 0011<<eff[1:0] (half), 1111 (word).
REQ-015 SHALL replicate store data: byte to all four lanes, half to both halves, word unchanged.
REQ-016 SHALL, in WAIT with mem_ack=1, capture mem_rdata, drop mem_req next cycle, enter DONE; mem_ack in REQ is also accepted (minimum latency).
REQ-017 SHALL, for loads, select lane by eff[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw full word.
REQ-018 SHALL, in DONE, pulse out_valid for exactly one cycle; out_wb=1 for loads, 0 for stores; out_data=0 for stores.
REQ-019 SHALL treat any other opcode as illegal: no memory request, DONE next cycle with out_err=1, out_wb=0.
REQ-020 SHALL ignore mem_ack while in IDLE or DONE.
REQ-021 Minimum latency accept-to-out_valid: 3 cycles.

Reset
REQ-022 SHALL, when reset=1 at a clock edge, enter IDLE regardless of state; all outputs 0 except in_ready=1.
REQ-023 SHALL, on reset mid-transaction, abandon it: mem_req low from the next edge, no out_valid.

Configuration
REQ-024 MISALIGN_TRAP_EN defined: half access with eff[0]=1 or word access with eff[1:0]!=0 SHALL skip memory, go to DONE with out_err=1, out_wb=0.
REQ-025 MISALIGN_TRAP_EN undefined: misaligned addresses SHALL be aligned down (clear low bits), access proceeds, out_err only for illegal opcode.

Structure
REQ-026 Shared package lsu_pkg SHALL hold opcode constants, FSM state encoding, access-size encoding (BYTE, HALF, WORD).
REQ-027 Combinational sub-module load_extend (rdata, byte offset, size, signed -> 32-bit result) SHALL perform REQ-017.

Verification
REQ-028 lw base=0x10 off=0x4, mem_rdata=0xDEADBEEF -> mem_addr=5, mem_be=1111, out_data=0xDEADBEEF, out_wb=1.
REQ-029 lb base=0x3 off=0 data=0x80FF7F01 -> mem_be=1000, out_data=0xFFFFFF80; lbu same -> 0x00000080.
REQ-030 sh base=0x8 off=2 rt=0x1234ABCD -> mem_we=1, mem_addr=2, mem_be=1100, mem_wdata=0xABCDABCD, out_wb=0.
REQ-031 lw base=0x6 off=0: with MISALIGN_TRAP_EN -> no mem_req, out_err=1; without -> mem_addr=1, mem_be=1111, out_err=0.
REQ-032 mem_ack delayed 4 cycles, reset at 2nd WAIT cycle -> mem_req 0 next cycle, no out_valid, in_ready=1.
REQ-033 opcode 0x00 -> no mem_req, out_valid after 2 cycles, out_err=1; lw off=0xFFFC base=0x4 -> eff=0, mem_addr=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared opcode constants, FSM states, access sizes and decode helpers for the load/store unit.
package lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

    typedef enum logic [1:0] {BYTE, HALF, WORD} access_size_e;

    typedef struct packed {
        logic         legal;
        logic         store;
        logic         sgn;
        access_size_e size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] opcode);
        op_info_t info;
        info = '{legal: 1'b1, store: 1'b0, sgn: 1'b0, size: WORD};
        case (opcode)
            OP_LB:   begin info.sgn = 1'b1; info.size = BYTE; end
            OP_LH:   begin info.sgn = 1'b1; info.size = HALF; end
            OP_LW:   info.size = WORD;
            OP_LBU:  info.size = BYTE;
            OP_LHU:  info.size = HALF;
            OP_SB:   begin info.store = 1'b1; info.size = BYTE; end
            OP_SH:   begin info.store = 1'b1; info.size = HALF; end
            OP_SW:   info.store = 1'b1;
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

    function automatic logic is_misaligned(input access_size_e size, input logic [1:0] off);
        case (size)
            HALF:    return off[0];
            WORD:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Clearing the low bits of the byte offset aligns the access down to its natural boundary.
    function automatic logic [1:0] align_offset(input access_size_e size, input logic [1:0] off);
        case (size)
            HALF:    return {off[1], 1'b0};
            WORD:    return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it to 32 bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0]  rdata,
    input  logic [1:0]   byte_off,
    input  access_size_e size,
    input  logic         sgn,
    output logic [31:0]  result
);

    logic [31:0] lane;

    always_comb begin
        lane = rdata >> {byte_off, 3'b000};
        case (size)
            BYTE:    result = {{24{sgn & lane[7]}}, lane[7:0]};
            HALF:    result = {{16{sgn & lane[15]}}, lane[15:0]};
            default: result = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MIPS-style load/store unit: one outstanding access, IDLE -> REQ -> WAIT -> DONE handshake.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_AW   = 5,
    parameter int OFFSET_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          in_opcode,
    input  logic [31:0]         in_base,
    input  logic [OFFSET_W-1:0] in_offset,
    input  logic [31:0]         in_wdata,
    input  logic [4:0]          in_rt,
    output logic                mem_req,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [3:0]          mem_be,
    output logic [31:0]         mem_wdata,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata,
    output logic                out_valid,
    output logic                out_wb,
    output logic [4:0]          out_rt,
    output logic [31:0]         out_data,
    output logic                out_err
);

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    lsu_state_e   state, state_n;

    logic [31:0]  eff;
    logic         eff_unused;
    op_info_t     in_info;
    logic         in_err;
    logic [31:0]  wdata_rep;

    logic [MEM_AW-1:0] addr_q;
    logic [1:0]   off_q;
    logic         store_q;
    logic         sgn_q;
    access_size_e size_q;
    logic         err_q;
    logic [4:0]   rt_q;
    logic [31:0]  wdata_q;
    logic [31:0]  rdata_q;
    logic [31:0]  load_result;

    assign eff        = in_base + 32'($signed(in_offset));
    assign eff_unused = ^eff[31:MEM_AW+2];
    assign in_info    = decode_op(in_opcode);
    assign in_err     = !in_info.legal || (TRAP_EN && is_misaligned(in_info.size, eff[1:0]));

    always_comb begin
        case (in_info.size)
            BYTE:    wdata_rep = {4{in_wdata[7:0]}};
            HALF:    wdata_rep = {2{in_wdata[15:0]}};
            default: wdata_rep = in_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            store_q <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= BYTE;
            err_q   <= 1'b0;
            rt_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                addr_q  <= eff[MEM_AW+1:2];
                off_q   <= align_offset(in_info.size, eff[1:0]);
                store_q <= in_info.store && in_info.legal;
                sgn_q   <= in_info.sgn;
                size_q  <= in_info.size;
                err_q   <= in_err;
                rt_q    <= in_rt;
                wdata_q <= wdata_rep;
            end
            if ((state == REQ || state == WAIT) && mem_ack) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    load_extend u_load_extend (
        .rdata    (rdata_q),
        .byte_off (off_q),
        .size     (size_q),
        .sgn      (sgn_q),
        .result   (load_result)
    );

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        out_valid = 1'b0;
        out_wb    = 1'b0;
        out_rt    = '0;
        out_data  = '0;
        out_err   = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = in_err ? DONE : REQ;
            end
            REQ, WAIT: begin
                mem_req  = 1'b1;
                mem_we   = store_q;
                mem_addr = addr_q;
                case (size_q)
                    BYTE:    mem_be = 4'b0001 << off_q;
                    HALF:    mem_be = 4'b0011 << off_q;
                    default: mem_be = 4'b1111;
                endcase
                if (store_q) mem_wdata = wdata_q;
                // An ack in REQ skips WAIT, giving the minimum accept-to-result latency.
                if (mem_ack)           state_n = DONE;
                else if (state == REQ) state_n = WAIT;
            end
            DONE: begin
                out_valid = 1'b1;
                out_rt    = rt_q;
                out_err   = err_q;
                out_wb    = !err_q && !store_q;
                if (!err_q && !store_q) out_data = load_result;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
